// File: rtl/row_buffer_ctrl_if.sv
// Pixel-in / window-out handshake bundle between the stream environment and
// the line-buffer sequencer.
interface row_buffer_ctrl_if #(
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT = 480
);
  localparam int unsigned CW = $clog2(LINE_WIDTH);
  localparam int unsigned RW = $clog2(FRAME_HEIGHT);

  logic          in_valid;
  logic          in_sop;
  logic          in_eop;
  logic          in_ready;
  logic          out_ready;
  logic          shift_en;
  logic          pad_sel;
  logic          win_valid;
  logic          win_sop;
  logic          win_eop;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          win_border;
  logic          err;

  // Stream source / window sink side
  modport master (
    output in_valid, in_sop, in_eop, out_ready,
    input  in_ready, shift_en, pad_sel, win_valid, win_sop, win_eop,
           win_col, win_row, win_border, err
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_sop, in_eop, out_ready,
    output in_ready, shift_en, pad_sel, win_valid, win_sop, win_eop,
           win_col, win_row, win_border, err
  );
endinterface

// File: rtl/row_buffer_ctrl.sv
// Sequencer for the cascaded 3x3 line-buffer datapath: controls shifting and
// zero padding, and tracks the window centre position and border flags.
module row_buffer_ctrl #(
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  row_buffer_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(LINE_WIDTH);
  localparam int unsigned RW = $clog2(FRAME_HEIGHT);
  // Shift distance from the newest pixel to the window centre
  localparam int unsigned D  = LINE_WIDTH + 1;
  localparam int unsigned DW = $clog2(D + 1);

  localparam logic [DW-1:0] LAST_CNT = DW'(D - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] fill_cnt;
  logic [DW-1:0] flush_cnt;
  logic          first_win;

  logic          accept;
  logic          produce;
  logic          frame_start;
  logic          in_ready_c;
  logic          shift_en_c;
  logic          pad_sel_c;

  logic          win_valid_q;
  logic          win_sop_q;
  logic          win_eop_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          err_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && bus.in_sop) state_nxt = FILL;
      end
      FILL: begin
        if (accept) begin
          if (bus.in_eop)                state_nxt = IDLE;
          else if (bus.in_sop)           state_nxt = FILL;
          else if (fill_cnt == LAST_CNT) state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          if (bus.in_eop)      state_nxt = FLUSH;
          else if (bus.in_sop) state_nxt = FILL;
        end
      end
      FLUSH: begin
        if (bus.out_ready && flush_cnt == LAST_CNT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and buffer control; everything is held off while in reset
  always_comb begin
    in_ready_c  = 1'b0;
    shift_en_c  = 1'b0;
    pad_sel_c   = 1'b0;
    accept      = 1'b0;
    produce     = 1'b0;
    frame_start = 1'b0;
    if (rst) begin
      case (state)
        IDLE, FILL: in_ready_c = 1'b1;
        STREAM:     in_ready_c = bus.out_ready;
        default:    in_ready_c = 1'b0;
      endcase
      accept = bus.in_valid & in_ready_c;
      case (state)
        IDLE: begin
          shift_en_c  = accept & bus.in_sop;
          frame_start = accept & bus.in_sop;
        end
        FILL: begin
          shift_en_c  = accept;
          frame_start = accept & bus.in_sop & ~bus.in_eop;
        end
        STREAM: begin
          shift_en_c  = accept;
          produce     = accept & (bus.in_eop | ~bus.in_sop);
          frame_start = accept & bus.in_sop & ~bus.in_eop;
        end
        FLUSH: begin
          shift_en_c  = bus.out_ready;
          pad_sel_c   = 1'b1;
          produce     = bus.out_ready;
        end
        default: ;
      endcase
    end
  end

  // Fill and flush progress counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && bus.in_sop) fill_cnt <= DW'(1);
        end
        FILL: begin
          if (accept) begin
            if (bus.in_eop)      fill_cnt <= '0;
            else if (bus.in_sop) fill_cnt <= DW'(1);
            else                 fill_cnt <= fill_cnt + DW'(1);
          end
        end
        STREAM: begin
          if (accept) begin
            if (bus.in_eop)      flush_cnt <= '0;
            else if (bus.in_sop) fill_cnt  <= DW'(1);
          end
        end
        FLUSH: begin
          if (bus.out_ready) flush_cnt <= flush_cnt + DW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky error: frame ended before the buffers were full
  always_ff @(posedge clk) begin
    if (!rst)                                          err_q <= 1'b0;
    else if (state == FILL && accept && bus.in_eop)    err_q <= 1'b1;
  end

  // Window centre tracking; outputs hold while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_valid_q <= 1'b0;
      win_sop_q   <= 1'b0;
      win_eop_q   <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      first_win   <= 1'b0;
    end else begin
      if (produce) begin
        win_valid_q <= 1'b1;
        win_eop_q   <= (state == FLUSH) && (flush_cnt == LAST_CNT);
        if (first_win) begin
          win_sop_q <= 1'b1;
          win_col_q <= '0;
          win_row_q <= '0;
          first_win <= 1'b0;
        end else begin
          win_sop_q <= 1'b0;
          if (win_col_q == COL_MAX) begin
            win_col_q <= '0;
            win_row_q <= (win_row_q == ROW_MAX) ? '0 : win_row_q + RW'(1);
          end else begin
            win_col_q <= win_col_q + CW'(1);
          end
        end
      end else if (bus.out_ready) begin
        win_valid_q <= 1'b0;
        win_sop_q   <= 1'b0;
        win_eop_q   <= 1'b0;
      end
      // An abort in STREAM only happens with out_ready high, so no held
      // window is disturbed by clearing the position here.
      if (frame_start) begin
        first_win <= 1'b1;
        if (state == STREAM) begin
          win_col_q <= '0;
          win_row_q <= '0;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.shift_en   = shift_en_c;
  assign bus.pad_sel    = pad_sel_c;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_sop    = win_sop_q;
  assign bus.win_eop    = win_eop_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.err        = err_q;
  assign bus.win_border = win_valid_q &
                          ((win_col_q == '0) || (win_col_q == COL_MAX) ||
                           (win_row_q == '0) || (win_row_q == ROW_MAX));
endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Directed bench for row_buffer_ctrl with a 4x3 frame geometry.
module tb_row_buffer_ctrl;
  localparam int unsigned W = 4;
  localparam int unsigned H = 3;
  // Bit k = expected border flag of raster window k; only (1,1),(2,1) are interior
  localparam logic [11:0] BORDER_MASK = 12'b1111_1001_1111;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  row_buffer_ctrl_if #(.LINE_WIDTH(W), .FRAME_HEIGHT(H)) bus ();

  row_buffer_ctrl #(.LINE_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"},  32'(bus.win_valid),  32'(0));
    chk({name, "_sop"},    32'(bus.win_sop),    32'(0));
    chk({name, "_eop"},    32'(bus.win_eop),    32'(0));
    chk({name, "_col"},    32'(bus.win_col),    32'(0));
    chk({name, "_row"},    32'(bus.win_row),    32'(0));
    chk({name, "_border"}, 32'(bus.win_border), 32'(0));
    chk({name, "_err"},    32'(bus.err),        32'(0));
    chk({name, "_shift"},  32'(bus.shift_en),   32'(0));
    chk({name, "_pad"},    32'(bus.pad_sel),    32'(0));
    chk({name, "_ready"},  32'(bus.in_ready),   32'(0));
  endtask

  task automatic idle_check(input string name);
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.win_valid), 32'(0));
    chk({name, "_eop"},   32'(bus.win_eop),   32'(0));
    chk({name, "_ready"}, 32'(bus.in_ready),  32'(1));
    chk({name, "_pad"},   32'(bus.pad_sel),   32'(0));
    @(posedge clk); #1;
  endtask

  // Streams one frame (optionally with a sop restart at pixel index abort_at)
  // and checks every consumed window against raster order until stop_at
  // windows of the final frame have been taken.
  task automatic run_frame(input string name, input int npix, input bit toggle,
                           input int abort_at, input int stop_at);
    int total, sent, got, pads, cyc, first_cyc;
    bit ordy, held;
    logic [1:0] h_col, h_row;
    logic h_sop, h_eop, h_bdr;
    logic [11:0] mask;
    mask  = BORDER_MASK;
    total = (abort_at >= 0) ? abort_at + npix : npix;
    sent = 0; got = 0; pads = 0; cyc = 0; first_cyc = -1; held = 1'b0;
    h_col = '0; h_row = '0; h_sop = 1'b0; h_eop = 1'b0; h_bdr = 1'b0;
    while (got < stop_at && cyc < 200) begin
      ordy = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.in_valid  = (sent < total);
      bus.in_sop    = (sent == 0) || (sent == abort_at);
      bus.in_eop    = (sent == total - 1);
      bus.out_ready = ordy;
      @(negedge clk);
      if (held) begin
        chk($sformatf("%s_hold_valid%0d", name, got), 32'(bus.win_valid),  32'(1));
        chk($sformatf("%s_hold_col%0d", name, got),   32'(bus.win_col),    32'(h_col));
        chk($sformatf("%s_hold_row%0d", name, got),   32'(bus.win_row),    32'(h_row));
        chk($sformatf("%s_hold_sop%0d", name, got),   32'(bus.win_sop),    32'(h_sop));
        chk($sformatf("%s_hold_eop%0d", name, got),   32'(bus.win_eop),    32'(h_eop));
        chk($sformatf("%s_hold_bdr%0d", name, got),   32'(bus.win_border), 32'(h_bdr));
      end
      if (bus.win_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.win_valid && ordy) begin
        chk($sformatf("%s_col%0d", name, got), 32'(bus.win_col),    32'(got % W));
        chk($sformatf("%s_row%0d", name, got), 32'(bus.win_row),    32'(got / W));
        chk($sformatf("%s_sop%0d", name, got), 32'(bus.win_sop),    32'(got == 0));
        chk($sformatf("%s_eop%0d", name, got), 32'(bus.win_eop),    32'(got == npix - 1));
        chk($sformatf("%s_bdr%0d", name, got), 32'(bus.win_border), 32'(mask[got]));
        got++;
      end
      if (!ordy && sent >= 5)
        chk($sformatf("%s_shift_stall%0d", name, cyc), 32'(bus.shift_en), 32'(0));
      if (bus.shift_en && bus.pad_sel) pads++;
      held  = bus.win_valid && !ordy;
      h_col = bus.win_col; h_row = bus.win_row;
      h_sop = bus.win_sop; h_eop = bus.win_eop; h_bdr = bus.win_border;
      if (bus.in_valid && bus.in_ready) begin
        if (sent == abort_at) got = 0;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_win_count"}, 32'(got), 32'(stop_at));
    if (!toggle) chk({name, "_first_cycle"}, 32'(first_cyc), 32'(6));
    if (stop_at == npix) chk({name, "_pad_shifts"}, 32'(pads), 32'(5));
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state, with an attempted sop that must be ignored
    bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Pixels without sop in IDLE are accepted and discarded
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("idle_ready%0d", i), 32'(bus.in_ready),  32'(1));
      chk($sformatf("idle_shift%0d", i), 32'(bus.shift_en),  32'(0));
      chk($sformatf("idle_valid%0d", i), 32'(bus.win_valid), 32'(0));
      chk($sformatf("idle_pad%0d", i),   32'(bus.pad_sel),   32'(0));
      @(posedge clk); #1;
    end

    // Continuous frame
    run_frame("cont", 12, 1'b0, -1, 12);
    idle_check("cont_after");

    // out_ready toggling every cycle
    run_frame("tog", 12, 1'b1, -1, 12);
    idle_check("tog_after");

    // eop on the 3rd pixel while filling
    bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_eop = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("err_p1_shift", 32'(bus.shift_en), 32'(1));
    @(posedge clk); #1;
    bus.in_sop = 1'b0;
    @(negedge clk);
    chk("err_p2_shift", 32'(bus.shift_en), 32'(1));
    @(posedge clk); #1;
    bus.in_eop = 1'b1;
    @(negedge clk);
    chk("err_p3_shift", 32'(bus.shift_en), 32'(1));
    chk("err_p3_err",   32'(bus.err),      32'(0));
    @(posedge clk); #1;
    bus.in_eop = 1'b0;
    @(negedge clk);
    chk("err_set",       32'(bus.err),       32'(1));
    chk("err_idle_shift", 32'(bus.shift_en), 32'(0));
    chk("err_idle_ready", 32'(bus.in_ready), 32'(1));
    chk("err_no_window",  32'(bus.win_valid), 32'(0));
    @(posedge clk); #1;
    run_frame("after_err", 12, 1'b0, -1, 12);
    chk("err_sticky", 32'(bus.err), 32'(1));
    idle_check("after_err_idle");

    // sop on the 8th pixel aborts the frame in STREAM
    run_frame("abort", 12, 1'b0, 7, 12);
    idle_check("abort_after");

    // Reset in the middle of FLUSH
    run_frame("pre_rst", 12, 1'b0, -1, 9);
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("rst_flush");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(bus.in_ready),  32'(1));
    chk("rst_rel_shift", 32'(bus.shift_en),  32'(0));
    chk("rst_rel_pad",   32'(bus.pad_sel),   32'(0));
    chk("rst_rel_valid", 32'(bus.win_valid), 32'(0));
    @(posedge clk); #1;
    run_frame("post_rst", 12, 1'b0, -1, 12);
    idle_check("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/row_buffer_ctrl.md
# row_buffer_ctrl

Sequencer for the cascaded line-buffer datapath feeding the 3x3 pixel filters. It accepts the raw pixel stream and decides when the line buffers shift and when they are padded with zeros. It also tells downstream when the buffer taps hold a complete window. It tracks the window-centre column/row, flags border windows, and drains the buffers with zero padding after end-of-packet so that every input pixel is emitted exactly once as a window centre.

## Interface
- LINE_WIDTH, 640, pixels per line; equals the line-buffer depth.
- FRAME_HEIGHT, 480, lines per frame; must be ≥ 2.
- CW, $clog2(LINE_WIDTH), column counter width.
- RW, $clog2(FRAME_HEIGHT), row counter width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream pixel valid.
- in_sop  in  1  first pixel of frame, qualified by in_valid.
- in_eop  in  1  last pixel of frame, qualified by in_valid.
- in_ready  out  1  controller accepts the pixel this cycle.
- out_ready  in  1  downstream accepts the window this cycle.
- shift_en  out  1  line-buffer clock enable; the buffers advance only when it is high.
- pad_sel  out  1  1 = the buffer input mux injects zero instead of the input pixel.
- win_valid  out  1  buffer taps hold a valid window.
- win_sop, win_eop  out  1  window centre is the first or last pixel of the frame.
- win_col  out  CW  window-centre column.
- win_row  out  RW  window-centre row.
- win_border  out  1  centre column is 0 or LINE_WIDTH-1, or centre row is 0 or FRAME_HEIGHT-1.
- err  out  1  sticky: eop arrived before the fill completed.

## Operation
- Define D = LINE_WIDTH+1. D is the shift distance from the newest pixel to the window centre.
- States: IDLE, FILL, STREAM, FLUSH. Reset: state IDLE; all counters 0; all outputs 0.
- in_ready: 1 in IDLE and FILL; equals out_ready in STREAM; 0 in FLUSH.
- accept = in_valid & in_ready. In IDLE, a pixel without sop is accepted and discarded, with shift_en = 0.
- shift_en = (accept & state≠IDLE) | (IDLE & accept & in_sop) | (FLUSH & out_ready).
- pad_sel = 1 only in FLUSH.
- IDLE → FILL on accept & in_sop. That pixel shifts in, and fill_cnt is set to 1.
- FILL: fill_cnt increments on each accept. At accept with fill_cnt = D-1, go to STREAM.
  - accept & in_eop in FILL: set err, go to IDLE.
  - accept & in_sop in FILL: restart; fill_cnt = 1.
- STREAM: each accept is a producing shift.
  - accept & in_eop: go to FLUSH with flush_cnt = 0.
  - accept & in_sop (no eop): abort the frame. Go to FILL with fill_cnt = 1, and reset win_col/win_row.
- FLUSH: each shift (out_ready) is a producing shift and increments flush_cnt. After the shift with flush_cnt = D-1, go to IDLE.
- Producing shift: on the next cycle win_valid = 1, and win_col/win_row/flags describe the new centre.
- win_valid clears after a cycle with out_ready = 1 and no producing shift. It holds, with all window outputs stable, while out_ready = 0.
- Window centre counters: start at (0,0) on the first producing shift of a frame and advance by one per later producing shift. Column wraps at LINE_WIDTH-1 and increments the row. The row wraps at FRAME_HEIGHT-1 to 0.
- win_sop = first window of the frame. win_eop = window from the final FLUSH shift.
- win_border is computed from the registered col/row and is valid whenever win_valid is high.
- err clears only on reset.

## Timing
- First window: win_valid rises 1 cycle after the (D+1)-th accepted frame pixel.
- Steady state: one window per cycle when in_valid = out_ready = 1. There are no bubbles at the FILL→STREAM or STREAM→FLUSH boundaries.
- FLUSH lasts exactly D shifts, plus any cycles where out_ready = 0. in_ready stays 0 throughout, so a next-frame sop waits.
- Back-to-back frames: IDLE is occupied for ≥ 1 cycle between the last FLUSH shift and the next sop acceptance.
- Reset mid-frame (rst = 0 on any edge) takes effect at that edge: state IDLE, outputs 0, the partial frame is discarded.

## Test plan
- W=4, H=3, continuous valid/ready, 12-pixel frame:
  - 5 fill cycles with no win_valid.
  - Then 12 windows at cols 0..3 and rows 0..2.
  - win_sop on (0,0); win_eop on (3,2).
  - Exactly 5 pad_sel shifts.
  - win_border = 0 only for centres (1,1) and (2,1).
- Same frame with out_ready toggling every cycle:
  - Window outputs are stable while out_ready = 0.
  - The 12 windows are identical to the first test, with no duplicates and no drops.
  - shift_en is never high while out_ready = 0 in STREAM/FLUSH.
- eop on the 3rd pixel (in FILL) → err = 1, state IDLE, no win_valid. A following valid frame still produces 12 windows.
- New sop on the 8th pixel in STREAM → the frame is aborted; the next windows start at (0,0) with win_sop = 1 after 5 more fill pixels.
- Pixels without sop while in IDLE → in_ready = 1, shift_en = 0, no state change.
- rst asserted mid-FLUSH → the next cycle has all outputs 0 and state IDLE. A new frame then behaves exactly as in the first test.
